imm_encoder: RTL and testbench
==============================

IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL expose port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL expose port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL expose port start, input, 1 bit: request an encode of value; sampled only in IDLE.
REQ-004 SHALL expose port value, input, 32 bits: constant to encode; captured on accepted start.
REQ-005 SHALL expose port busy, output, 1 bit: high in SEARCH and DONE.
REQ-006 SHALL expose port done, output, 1 bit: one-cycle pulse, high only in DONE.
REQ-007 SHALL expose port found, output, 1 bit: encoding exists; valid while done=1.
REQ-008 SHALL expose port inv, output, 1 bit: encoding is of ~value (MVN form); valid while done=1.
REQ-009 SHALL expose port imm12, output, 12 bits: {rot[3:0], imm8[7:0]}, meaning imm8 ROR (2*rot); valid while done=1.

Function
REQ-010 SHALL implement the FSM IDLE -> SEARCH -> DONE -> IDLE.
REQ-011 In IDLE with start=1, SHALL capture value into a working register W and ~value into a working register V, clear rot counter k, and go to SEARCH next cycle.
REQ-012 Each SEARCH cycle SHALL test W[31:8]==0 (match) and V[31:8]==0 (inverted match) for current k, where W = value ROL 2k and V = ~value ROL 2k.
REQ-013 Priority SHALL be: smallest k first; at equal k, a non-inverted match beats an inverted match.
REQ-014 On a match SHALL latch found=1, inv=0, imm12={k, W[7:0]}; on an inverted match only, SHALL latch found=1, inv=1, imm12={k, V[7:0]}; in both cases SHALL go to DONE.
REQ-015 With no match and k<15, SHALL rotate W and V left by 2, increment k, and stay in SEARCH.
REQ-016 With no match at k=15, SHALL latch found=0, inv=0, imm12=0 and go to DONE.
REQ-017 Latency SHALL be: start accepted in cycle N; a match at k raises done in cycle N+2+k; no encoding raises done in cycle N+17.
REQ-018 DONE SHALL last exactly one cycle and return to IDLE; a start in that DONE cycle SHALL be ignored.
REQ-019 start while busy=1 SHALL be ignored; value changes after capture SHALL have no effect.
REQ-020 found, inv and imm12 SHALL hold their last latched values in IDLE until the next DONE.
REQ-021 value=0 SHALL encode as found=1, inv=0, imm12=0x000; value=0xFFFFFFFF SHALL encode as found=1, inv=1, imm12=0x000.

Reset
REQ-022 reset=1 SHALL, at the next edge, force IDLE, k=0, W=0, V=0, busy=0, done=0, found=0, inv=0, imm12=0.
REQ-023 reset SHALL take priority over start and over any SEARCH or DONE activity, abort any search in progress, and produce no done pulse.

Structure
REQ-024 A shared package SHALL hold the state enum (IDLE, SEARCH, DONE) and constants ROT_STEPS=16, IMM8_W=8, ROT_W=4.
REQ-025 A combinational sub-module imm_fit SHALL take a 32-bit word and return fits (bits [31:8] zero) plus imm8; it SHALL be instantiated once for W and once for V.

Verification
REQ-026 value=0x000000FF, start at N -> done at N+2, found=1, inv=0, imm12=0x0FF.
REQ-027 value=0xFF000000 -> done at N+6, found=1, inv=0, imm12=0x4FF.
REQ-028 value=0xF000000F -> done at N+4, found=1, inv=0, imm12=0x2FF.
REQ-029 value=0xFFFFFF00 -> done at N+2, found=1, inv=1, imm12=0x0FF.
REQ-030 value=0x00000102 -> done at N+17, found=0, inv=0, imm12=0x000; a start pulsed at N+5 is ignored.
REQ-031 reset asserted at N+3 during a 0x00000102 search -> next cycle IDLE, busy=0, outputs zero, no done pulse; a new start at 0x000000FF then completes normally in 2 cycles.

Source files
------------

// File: rtl/imm_encoder_pkg.sv
// Shared definitions for the rotated-immediate encoder.
// Holds the controller state encoding and the immediate field geometry:
// an 8-bit payload rotated right by an even amount selected by a 4-bit field.
package imm_encoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int ROT_STEPS = 16;
  localparam int IMM8_W    = 8;
  localparam int ROT_W     = 4;

  // Last rotation index tried before giving up.
  localparam logic [ROT_W-1:0] K_LAST = ROT_W'(ROT_STEPS - 1);

endpackage

// File: rtl/imm_encoder_imm_fit.sv
// imm_fit: combinational test of whether a 32-bit word is directly
// representable as an 8-bit payload (upper 24 bits zero).
// Ports:
//   word  - candidate word (already rotated by the caller)
//   fits  - 1 when word[31:8] is all zero
//   imm8  - low 8 bits of word, the payload when fits=1
module imm_fit
  import imm_encoder_pkg::*;
(
  input  logic [31:0]       word,
  output logic              fits,
  output logic [IMM8_W-1:0] imm8
);

  assign fits = (word[31:IMM8_W] == '0);
  assign imm8 = word[IMM8_W-1:0];

endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: iterative search for an ARM-style rotated immediate.
// A captured constant is rotated left by 2 each cycle; the first rotation k
// at which the constant (or its complement) fits in 8 bits yields
// imm12 = {k, imm8}, i.e. value == imm8 ROR (2*k) (or ~value for MVN form).
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous active-high reset
//   start  - request an encode; only honoured in IDLE
//   value  - constant to encode, captured when start is accepted
//   busy   - high while searching or reporting
//   done   - one-cycle pulse when the result is valid
//   found  - an encoding exists
//   inv    - the encoding is of ~value
//   imm12  - {rot[3:0], imm8[7:0]}; held until the next result
module imm_encoder
  import imm_encoder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] value,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic        inv,
  output logic [11:0] imm12
);

  state_t             state;
  state_t             state_nxt;
  logic [31:0]        w;
  logic [31:0]        v;
  logic [ROT_W-1:0]   k;

  logic               w_fits;
  logic               v_fits;
  logic [IMM8_W-1:0]  w_imm8;
  logic [IMM8_W-1:0]  v_imm8;

  imm_fit u_fit_w (
    .word (w),
    .fits (w_fits),
    .imm8 (w_imm8)
  );

  imm_fit u_fit_v (
    .word (v),
    .fits (v_fits),
    .imm8 (v_imm8)
  );

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SEARCH;
      SEARCH:  if (w_fits || v_fits || (k == K_LAST)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      w     <= '0;
      v     <= '0;
      k     <= '0;
      found <= 1'b0;
      inv   <= 1'b0;
      imm12 <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            w <= value;
            v <= ~value;
            k <= '0;
          end
        end
        SEARCH: begin
          // Direct form wins over MVN form at the same rotation.
          if (w_fits) begin
            found <= 1'b1;
            inv   <= 1'b0;
            imm12 <= {k, w_imm8};
          end else if (v_fits) begin
            found <= 1'b1;
            inv   <= 1'b1;
            imm12 <= {k, v_imm8};
          end else if (k == K_LAST) begin
            found <= 1'b0;
            inv   <= 1'b0;
            imm12 <= '0;
          end else begin
            w <= {w[29:0], w[31:30]};
            v <= {v[29:0], v[31:30]};
            k <= k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] value;
  logic        busy;
  logic        done;
  logic        found;
  logic        inv;
  logic [11:0] imm12;

  int n_assert = 0;
  int n_fail   = 0;

  imm_encoder dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .value (value),
    .busy  (busy),
    .done  (done),
    .found (found),
    .inv   (inv),
    .imm12 (imm12)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: value is encodable at rotation r when some 8-bit x gives
  // x ROR 2r == value, i.e. value ROL 2r is below 256. Smallest r wins,
  // direct form before MVN form. Latency is 2+r, or 17 with no encoding.
  function automatic void model(input logic [31:0] val, output logic f, output logic i,
                                output logic [11:0] imm, output int lat);
    logic [63:0] t;
    logic [63:0] tn;
    logic [31:0] rl;
    logic [31:0] nrl;
    f = 1'b0; i = 1'b0; imm = 12'h000; lat = 17;
    for (int r = 0; r < 16; r++) begin
      t   = {val, val} << (2 * r);
      tn  = {~val, ~val} << (2 * r);
      rl  = t[63:32];
      nrl = tn[63:32];
      if (rl < 256) begin
        f = 1'b1; i = 1'b0; imm = {4'(r), rl[7:0]}; lat = 2 + r;
        return;
      end else if (nrl < 256) begin
        f = 1'b1; i = 1'b1; imm = {4'(r), nrl[7:0]}; lat = 2 + r;
        return;
      end
    end
  endfunction

  // Start an encode in cycle N, scramble value every later cycle, optionally
  // pulse start in cycle N+pulse_at, and pulse start during DONE as well.
  task automatic encode(input logic [31:0] val, input int pulse_at);
    logic       ef;
    logic       ei;
    logic [11:0] eimm;
    int         elat;
    int         cyc;
    bit         seen;
    model(val, ef, ei, eimm, elat);
    @(negedge clk);
    start = 1'b1;
    value = val;
    cyc   = 0;
    seen  = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      value = $urandom;
      start = (cyc == pulse_at);
      if (done) begin
        seen = 1;
        chk($sformatf("latency_%08h", val), cyc, elat);
        chk($sformatf("found_%08h", val), {31'd0, found}, {31'd0, ef});
        chk($sformatf("inv_%08h", val), {31'd0, inv}, {31'd0, ei});
        chk($sformatf("imm12_%08h", val), {20'd0, imm12}, {20'd0, eimm});
        chk("busy_done", {31'd0, busy}, 32'd1);
        start = 1'b1;
      end else if (busy !== 1'b1) begin
        chk("busy_search", {31'd0, busy}, 32'd1);
      end
    end
    if (!seen) chk($sformatf("timeout_%08h", val), 32'd0, 32'd1);
    @(negedge clk);
    start = 1'b0;
    chk("idle_after_done", {30'd0, busy, done}, 32'd0);
    chk("hold_imm12", {19'd0, found, inv, imm12}, {19'd0, ef, ei, eimm});
  endtask

  logic [31:0] rv;
  int          dcount;

  initial begin
    reset = 1'b1;
    start = 1'b1;
    value = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    chk("reset_state", {18'd0, busy, done, found, inv, imm12}, 32'd0);
    reset = 1'b0;
    start = 1'b0;

    encode(32'h0000_0000, -1);
    encode(32'hFFFF_FFFF, -1);
    encode(32'h0000_00FF, -1);
    encode(32'hFF00_0000, -1);
    encode(32'hF000_000F, -1);
    encode(32'hFFFF_FF00, -1);
    encode(32'h0000_0102, 5);

    // Reset in the middle of a search: no done pulse, outputs cleared.
    encode(32'hFF00_0000, -1);
    @(negedge clk); start = 1'b1; value = 32'h0000_0102;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("abort_state", {18'd0, busy, done, found, inv, imm12}, 32'd0);
    dcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    chk("abort_no_done", dcount, 0);
    encode(32'h0000_00FF, -1);

    // Random constants, plus ones built to be encodable directly or inverted.
    for (int n = 0; n < 12; n++) begin
      rv = $urandom;
      case (n % 3)
        0: encode(rv, -1);
        1: begin
          rv = ({24'd0, rv[7:0]} >> (2 * rv[11:8])) | ({24'd0, rv[7:0]} << (32 - 2 * rv[11:8]));
          encode(rv, 3);
        end
        default: begin
          rv = ({24'd0, rv[7:0]} >> (2 * rv[11:8])) | ({24'd0, rv[7:0]} << (32 - 2 * rv[11:8]));
          encode(~rv, -1);
        end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
